// File: rtl/ahb_line_fetch_if.sv
// ---------------------------------------------------------------------------
// ahb_line_fetch_if
//   AHB-Lite read-path signal bundle between the line-fetch master and the
//   bus/slave side.
//
//   HADDR   master -> slave  byte address of the current address phase
//   HTRANS  master -> slave  IDLE=00, NONSEQ=10, SEQ=11
//   HBURST  master -> slave  burst type (INCR4/8/16)
//   HSIZE   master -> slave  transfer size (word)
//   HWRITE  master -> slave  always 0 (read-only master)
//   HRDATA  slave -> master  read data for the current data phase
//   HREADY  slave -> master  1 = current data phase completes this edge
//   HRESP   slave -> master  0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
interface ahb_line_fetch_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HBURST;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic [31:0]           HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HADDR, HTRANS, HBURST, HSIZE, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HBURST, HSIZE, HWRITE,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_line_fetch.sv
// ---------------------------------------------------------------------------
// ahb_line_fetch
//   I-cache refill engine. On a miss it issues one line-aligned incrementing
//   AHB-Lite read burst, packs the returned words into a cache line and
//   pulses mem_ready for one cycle when the line is complete.
//
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low
//   mem_req       miss request (level, held until mem_ready)
//   mem_addr      miss address; line-offset bits are ignored
//   mem_data_out  assembled line, word i in bits [32i+31:32i]
//   mem_ready     one-cycle pulse, mem_data_out valid
//   mem_err       high together with mem_ready if the burst got an ERROR
//   ahb           AHB-Lite master port (see ahb_line_fetch_if)
// ---------------------------------------------------------------------------
module ahb_line_fetch #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int LINE_WORDS = 4,
    localparam int LINE_BITS  = LINE_WORDS * 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_BITS-1:0]  mem_data_out,
    output logic                  mem_ready,
    output logic                  mem_err,
    ahb_line_fetch_if.master      ahb
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    localparam logic [2:0] BURST_CODE = (LINE_WORDS == 16) ? 3'b111 :
                                        (LINE_WORDS == 8)  ? 3'b101 : 3'b011;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state;
    logic [ADDR_WIDTH-OFF_W-1:0] base_q;
    logic [CNT_W-1:0]        addr_cnt;
    logic [CNT_W-1:0]        data_cnt;
    logic                    addr_done;
    logic                    err_q;
    logic [LINE_BITS-1:0]    line_q;
    logic                    unused_offset;

    // The line offset is dropped when the base is latched.
    assign unused_offset = ^mem_addr[OFF_W-1:0];

    // Base is line-aligned, so the beat address is a plain concatenation.
    assign ahb.HADDR  = {base_q, addr_cnt, 2'b00};
    assign ahb.HTRANS = (state == S_ADDR)                 ? TRANS_NONSEQ :
                        (state == S_BURST && !addr_done)  ? TRANS_SEQ    : TRANS_IDLE;
    assign ahb.HBURST = BURST_CODE;
    assign ahb.HSIZE  = 3'b010;
    assign ahb.HWRITE = 1'b0;

    assign mem_data_out = line_q;
    assign mem_ready    = (state == S_DONE);
    assign mem_err      = (state == S_DONE) && err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            base_q    <= '0;
            addr_cnt  <= '0;
            data_cnt  <= '0;
            addr_done <= 1'b0;
            err_q     <= 1'b0;
            line_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        state     <= S_ADDR;
                        base_q    <= mem_addr[ADDR_WIDTH-1:OFF_W];
                        addr_cnt  <= '0;
                        data_cnt  <= '0;
                        addr_done <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                // NONSEQ phase for beat 0; no data phase is in flight yet.
                S_ADDR: begin
                    if (ahb.HREADY) begin
                        state    <= S_BURST;
                        addr_cnt <= addr_cnt + CNT_W'(1);
                    end
                end
                // Every cycle in BURST has a data phase in flight, and an
                // accepted address phase always coincides with HREADY=1.
                S_BURST: begin
                    if (ahb.HRESP) begin
                        // First ERROR cycle (HREADY=0): withdraw the pending
                        // address so the rest of the burst is never issued.
                        err_q <= 1'b1;
                        if (ahb.HREADY) begin
                            state <= S_DONE;
                        end else begin
                            addr_done <= 1'b1;
                        end
                    end else if (ahb.HREADY) begin
                        if (!addr_done) begin
                            if (addr_cnt == LAST_BEAT) begin
                                addr_done <= 1'b1;
                            end else begin
                                addr_cnt <= addr_cnt + CNT_W'(1);
                            end
                        end
                        line_q[{data_cnt, 5'd0} +: 32] <= ahb.HRDATA;
                        if (data_cnt == LAST_BEAT) begin
                            state <= S_DONE;
                        end else begin
                            data_cnt <= data_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
